rf_write_arbiter: RTL and testbench

Write-port arbiter and result scoreboard for the 32x32 register file. Shares the file's single write port (LE/RW/PW) between the pipeline writeback stage and one multicycle result source, such as a mult/div or long-latency load return. Tracks registers reserved by outstanding multicycle operations so decode can detect read hazards on RA/RB. Bounds multicycle starvation by stalling writeback.

---
 rtl/rf_write_arbiter.sv | 129 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter with multicycle scoreboard
//
// Purpose:
//   Shares the register file's single write port (LE/RW/PW) between the
//   pipeline writeback stage (wb_*) and one multicycle result source (mc_*).
//   Writeback normally has priority. A 32-bit scoreboard records registers
//   reserved by outstanding multicycle ops so decode can see hazards on RA/RB.
//
// Optional feature:
//   RF_ARB_STARVE_EN - when defined, a starvation counter forces a multicycle
//   grant (stalling writeback) after STARVE_LIMIT consecutive denials. When
//   undefined, multicycle results only win idle writeback cycles and wb_stall
//   is tied low.
//
// Ports:
//   Clk, Reset_n            clock, synchronous active-low reset
//   wb_le, wb_rw, wb_pw     writeback write request / destination / data
//   wb_stall                writeback denied this cycle (re-present next cycle)
//   mc_issue, mc_issue_rd   reserve a destination for a new multicycle op
//   mc_valid, mc_rw, mc_pw  multicycle result request / destination / data
//   mc_ready                multicycle result accepted this cycle
//   RA, RB                  decode read selectors
//   busy_a, busy_b          RA/RB currently reserved
//   LE, RW, PW              register file write port

module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        wb_le,
  input  logic [4:0]  wb_rw,
  input  logic [31:0] wb_pw,
  output logic        wb_stall,
  input  logic        mc_issue,
  input  logic [4:0]  mc_issue_rd,
  input  logic        mc_valid,
  input  logic [4:0]  mc_rw,
  input  logic [31:0] mc_pw,
  output logic        mc_ready,
  input  logic [4:0]  RA,
  input  logic [4:0]  RB,
  output logic        busy_a,
  output logic        busy_b,
  output logic        LE,
  output logic [4:0]  RW,
  output logic [31:0] PW
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_limit
    $error("rf_write_arbiter: STARVE_LIMIT does not fit in CNT_W bits");
  end

  logic [31:0] busy;
  logic        wb_req;
  logic        mc_req;
  logic        force_mc;
  logic        grant_wb;
  logic        grant_mc;

  // Writes to r0 from writeback are not real requests and never block MC.
  assign wb_req = wb_le & (wb_rw != 5'd0);
  assign mc_req = mc_valid;

`ifdef RF_ARB_STARVE_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counter sitting at the limit means MC has been denied LIMIT cycles in a row.
  assign force_mc = (starve_cnt == LIMIT) & mc_req;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      starve_cnt <= '0;
    end else if (mc_req & ~grant_mc) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_mc = 1'b0;
`endif

  // Reset gates every grant so the port is quiet while Reset_n is low.
  assign grant_mc = Reset_n & mc_req & (force_mc | ~wb_req);
  assign grant_wb = Reset_n & wb_req & ~force_mc;
  assign wb_stall = Reset_n & force_mc & wb_req;
  assign mc_ready = grant_mc;

  always_comb begin
    LE = 1'b0;
    RW = 5'd0;
    PW = 32'd0;
    if (grant_wb) begin
      LE = 1'b1;
      RW = wb_rw;
      PW = wb_pw;
    end else if (grant_mc) begin
      // A result to r0 is consumed but its write is suppressed.
      LE = (mc_rw != 5'd0);
      RW = mc_rw;
      PW = mc_pw;
    end
  end

  // Clear first, then set: the later assignment wins when a new reservation
  // targets the register being retired in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      busy <= '0;
    end else begin
      if (grant_mc) begin
        busy[mc_rw] <= 1'b0;
      end
      if (mc_issue && (mc_issue_rd != 5'd0)) begin
        busy[mc_issue_rd] <= 1'b1;
      end
    end
  end

  assign busy_a = Reset_n & busy[RA];
  assign busy_b = Reset_n & busy[RB];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter

module tb_rf_write_arbiter;

  localparam int STARVE_LIMIT = 4;
`ifdef RF_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        wb_le;
  logic [4:0]  wb_rw;
  logic [31:0] wb_pw;
  logic        wb_stall;
  logic        mc_issue;
  logic [4:0]  mc_issue_rd;
  logic        mc_valid;
  logic [4:0]  mc_rw;
  logic [31:0] mc_pw;
  logic        mc_ready;
  logic [4:0]  RA, RB;
  logic        busy_a, busy_b;
  logic        LE;
  logic [4:0]  RW;
  logic [31:0] PW;

  always #5 Clk = ~Clk;

  rf_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(3)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wb_le(wb_le), .wb_rw(wb_rw), .wb_pw(wb_pw), .wb_stall(wb_stall),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_rw(mc_rw), .mc_pw(mc_pw), .mc_ready(mc_ready),
    .RA(RA), .RB(RB), .busy_a(busy_a), .busy_b(busy_b),
    .LE(LE), .RW(RW), .PW(PW)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: reserved-register set and length of the current run of
  // consecutive cycles in which a pending MC result was refused.
  bit m_busy [32];
  int m_denied = 0;

  // DUT outputs as sampled on the last falling edge.
  logic        s_le, s_stall, s_ready, s_ba, s_bb;
  logic [4:0]  s_rw;
  logic [31:0] s_pw;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit wbr, forced, e_ready, e_stall, e_wbg, e_le, e_ba, e_bb;
    logic [4:0]  e_rw;
    logic [31:0] e_pw;
    @(negedge Clk);
    wbr     = wb_le && (wb_rw != 0);
    forced  = STARVE_EN && (m_denied == STARVE_LIMIT) && mc_valid;
    e_ready = Reset_n && mc_valid && (forced || !wbr);
    e_stall = Reset_n && forced && wbr;
    e_wbg   = Reset_n && wbr && !forced;
    e_le    = e_wbg ? 1'b1 : (e_ready ? (mc_rw != 0) : 1'b0);
    e_rw    = e_wbg ? wb_rw : (e_ready ? mc_rw : 5'd0);
    e_pw    = e_wbg ? wb_pw : (e_ready ? mc_pw : 32'd0);
    e_ba    = Reset_n && m_busy[RA];
    e_bb    = Reset_n && m_busy[RB];
    s_le = LE; s_stall = wb_stall; s_ready = mc_ready;
    s_rw = RW; s_pw = PW; s_ba = busy_a; s_bb = busy_b;
    chk("LE", {31'd0, s_le}, {31'd0, e_le});
    chk("RW", {27'd0, s_rw}, {27'd0, e_rw});
    chk("PW", s_pw, e_pw);
    chk("mc_ready", {31'd0, s_ready}, {31'd0, e_ready});
    chk("wb_stall", {31'd0, s_stall}, {31'd0, e_stall});
    chk("busy_a", {31'd0, s_ba}, {31'd0, e_ba});
    chk("busy_b", {31'd0, s_bb}, {31'd0, e_bb});
    @(posedge Clk);
    if (!Reset_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_denied = 0;
    end else begin
      if (mc_valid && !e_ready) m_denied = (m_denied < STARVE_LIMIT) ? m_denied + 1 : STARVE_LIMIT;
      else m_denied = 0;
      if (e_ready) m_busy[mc_rw] = 1'b0;
      if (mc_issue && mc_issue_rd != 0) m_busy[mc_issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wb_le = 0; wb_rw = 0; wb_pw = 0;
    mc_issue = 0; mc_issue_rd = 0;
    mc_valid = 0; mc_rw = 0; mc_pw = 0;
    RA = 0; RB = 0;
  endtask

  bit pend;

  initial begin
    Reset_n = 1'b0;
    idle_inputs();

    // Reset with active requests: port quiet, issue ignored.
    wb_le = 1; wb_rw = 3; wb_pw = 32'h55; mc_valid = 1; mc_rw = 4; mc_pw = 32'h66;
    mc_issue = 1; mc_issue_rd = 3; RA = 3; RB = 4;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_LE", {31'd0, s_le}, 32'd0);
      chk("rst_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_stall", {31'd0, s_stall}, 32'd0);
    end
    Reset_n = 1'b1;
    idle_inputs(); RA = 3; RB = 4;
    step();
    chk("post_rst_busy_a", {31'd0, s_ba}, 32'd0);

    // WB beats MC.
    wb_le = 1; wb_rw = 5; wb_pw = 32'h14; mc_valid = 1; mc_rw = 7; mc_pw = 32'h77;
    step();
    chk("wb_pri_LE", {31'd0, s_le}, 32'd1);
    chk("wb_pri_RW", {27'd0, s_rw}, 32'd5);
    chk("wb_pri_PW", s_pw, 32'h14);
    chk("wb_pri_ready", {31'd0, s_ready}, 32'd0);
    idle_inputs();
    step();

    // r0 handling.
    mc_valid = 1; mc_rw = 0; mc_pw = 32'h99;
    step();
    chk("r0_ready", {31'd0, s_ready}, 32'd1);
    chk("r0_LE", {31'd0, s_le}, 32'd0);
    wb_le = 1; wb_rw = 0; wb_pw = 32'h1;
    step();
    chk("wb_r0_ready", {31'd0, s_ready}, 32'd1);
    chk("wb_r0_stall", {31'd0, s_stall}, 32'd0);
    idle_inputs();
    step();

    // Scoreboard set / same-cycle set-wins / clear.
    mc_issue = 1; mc_issue_rd = 12;
    step();
    mc_issue = 0; RA = 12; RB = 12;
    step();
    chk("sb_set", {31'd0, s_ba}, 32'd1);
    mc_valid = 1; mc_rw = 12; mc_pw = 32'hC; mc_issue = 1; mc_issue_rd = 12;
    step();
    chk("sb_xfer_ready", {31'd0, s_ready}, 32'd1);
    mc_valid = 0; mc_issue = 0;
    step();
    chk("sb_set_wins", {31'd0, s_ba}, 32'd1);
    mc_valid = 1;
    step();
    mc_valid = 0;
    step();
    chk("sb_clear", {31'd0, s_bb}, 32'd0);
    idle_inputs();
    step();

`ifdef RF_ARB_STARVE_EN
    // Starvation: denied 4 cycles, forced in the 5th, WB back on the 6th.
    wb_le = 1; wb_rw = 3; wb_pw = 32'h33; mc_valid = 1; mc_rw = 9; mc_pw = 32'hABCD;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("starve_denied", {31'd0, s_ready}, 32'd0);
    end
    step();
    chk("force_ready", {31'd0, s_ready}, 32'd1);
    chk("force_stall", {31'd0, s_stall}, 32'd1);
    chk("force_RW", {27'd0, s_rw}, 32'd9);
    chk("force_PW", s_pw, 32'hABCD);
    mc_rw = 10; mc_pw = 32'h1234;
    step();
    chk("after_force_stall", {31'd0, s_stall}, 32'd0);
    chk("after_force_RW", {27'd0, s_rw}, 32'd3);
`else
    // No starvation relief: MC waits while WB is busy.
    wb_le = 1; wb_rw = 3; wb_pw = 32'h33; mc_valid = 1; mc_rw = 9; mc_pw = 32'hABCD;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("nostarve_ready", {31'd0, s_ready}, 32'd0);
      chk("nostarve_stall", {31'd0, s_stall}, 32'd0);
    end
    wb_le = 0;
    step();
    chk("nostarve_release", {31'd0, s_ready}, 32'd1);
`endif
    idle_inputs();
    step();

    // Randomized traffic honouring both source protocols.
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      Reset_n = ($urandom_range(0, 199) != 0);
      if (!s_stall) begin
        wb_le = ($urandom_range(0, 3) != 0);
        wb_rw = 5'($urandom_range(0, 31));
        wb_pw = $urandom;
      end
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        mc_rw = 5'($urandom_range(0, 31));
        mc_pw = $urandom;
      end
      mc_valid = pend;
      mc_issue = ($urandom_range(0, 3) == 0);
      mc_issue_rd = 5'($urandom_range(0, 31));
      RA = 5'($urandom_range(0, 31));
      RB = 5'($urandom_range(0, 31));
      step();
      if (s_ready) pend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
